// File: rtl/dected_b_pkg.sv
// rtl/dected_b_pkg.sv - B-matrix 32/8 code constants and status encodings
package dected_b_pkg;

  localparam int DATA_W = 32;
  localparam int PAR_W  = 8;

  // Column i of H for data bit i; bit k of each entry feeds check bit k.
  localparam logic [PAR_W-1:0] H_COL [0:DATA_W-1] = '{
    8'h98, 8'h51, 8'h13, 8'hD0, 8'h31, 8'h29, 8'h45, 8'hC4,
    8'h52, 8'h8A, 8'h62, 8'h32, 8'h2A, 8'h83, 8'h1A, 8'h2C,
    8'h64, 8'hA2, 8'h25, 8'h34, 8'h92, 8'h15, 8'h54, 8'h99,
    8'hC8, 8'h94, 8'h4C, 8'hA8, 8'h0E, 8'h85, 8'h49, 8'hE0
  };

  typedef enum logic [1:0] {
    STATUS_CLEAN  = 2'b00,
    STATUS_DATA   = 2'b01,
    STATUS_PARITY = 2'b10,
    STATUS_UNCORR = 2'b11
  } status_t;

  localparam logic [5:0] POS_NONE = 6'd63;

  function automatic logic [PAR_W-1:0] calc_parity(input logic [DATA_W-1:0] data);
    logic [PAR_W-1:0] p;
    p = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (data[i]) p = p ^ H_COL[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/dected_b_syndrome.sv
// rtl/dected_b_syndrome.sv - recomputes check bits and forms the syndrome
module dected_b_syndrome
  import dected_b_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [PAR_W-1:0]  parity,
  output logic [PAR_W-1:0]  syndrome
);

  assign syndrome = calc_parity(data) ^ parity;

endmodule

// File: rtl/dected_decoder_b.sv
// rtl/dected_decoder_b.sv - two-stage single-error-correcting decoder with
// valid/ready flow control and saturating error counters
module dected_decoder_b
  import dected_b_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic [7:0]        in_parity,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [1:0]        out_status,
  output logic [5:0]        out_err_pos,
  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  corr_count,
  output logic [CNT_W-1:0]  uncorr_count
);

  logic              s1_valid;
  logic [31:0]       s1_data;
  logic [7:0]        s1_syn;
  logic [7:0]        syn_in;
  logic              s1_adv;
  logic              s2_adv;
  logic [31:0]       dec_data;
  status_t           dec_status;
  logic [5:0]        dec_pos;
  logic              out_fire;

  dected_b_syndrome u_syndrome (
    .data     (in_data),
    .parity   (in_parity),
    .syndrome (syn_in)
  );

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    dec_data   = s1_data;
    dec_status = STATUS_UNCORR;
    dec_pos    = POS_NONE;
    if (s1_syn == 8'h00) begin
      dec_status = STATUS_CLEAN;
    end else if ($onehot(s1_syn)) begin
      dec_status = STATUS_PARITY;
      for (int k = 0; k < PAR_W; k++) begin
        if (s1_syn[k]) dec_pos = 6'(32 + k);
      end
    end else begin
      // Columns are unique and weight >= 2, so at most one entry can match.
      for (int i = 0; i < DATA_W; i++) begin
        if (s1_syn == H_COL[i]) begin
          dec_data[i] = ~s1_data[i];
          dec_status  = STATUS_DATA;
          dec_pos     = 6'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s1_data      <= '0;
      s1_syn       <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_status   <= STATUS_CLEAN;
      out_err_pos  <= POS_NONE;
      corr_count   <= '0;
      uncorr_count <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_data <= in_data;
          s1_syn  <= syn_in;
        end
      end
      // Output registers only move when the consumer can take a new word.
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data    <= dec_data;
          out_status  <= dec_status;
          out_err_pos <= dec_pos;
        end
      end
      if (cnt_clear) begin
        corr_count   <= '0;
        uncorr_count <= '0;
      end else if (out_fire) begin
        if ((out_status == STATUS_DATA || out_status == STATUS_PARITY) && corr_count != '1)
          corr_count <= corr_count + 1'b1;
        if (out_status == STATUS_UNCORR && uncorr_count != '1)
          uncorr_count <= uncorr_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dected_decoder_b.sv
// tb/tb_dected_decoder_b.sv - directed self-checking bench for dected_decoder_b
module tb_dected_decoder_b;

  localparam int CNT_W = 2;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic [7:0]        in_parity;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic [1:0]        out_status;
  logic [5:0]        out_err_pos;
  logic              cnt_clear;
  logic [CNT_W-1:0]  corr_count;
  logic [CNT_W-1:0]  uncorr_count;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_corr = 0;
  int exp_uncorr = 0;

  dected_decoder_b #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_parity    (in_parity),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_status   (out_status),
    .out_err_pos  (out_err_pos),
    .cnt_clear    (cnt_clear),
    .corr_count   (corr_count),
    .uncorr_count (uncorr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One word through an idle pipeline with out_ready high, then counter check.
  task automatic run_word(input string tag, input logic [31:0] d, input logic [7:0] p,
                          input logic [31:0] ed, input logic [1:0] es, input logic [5:0] ep);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_parity = p;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, ".lat"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".data"}, 64'(out_data), 64'(ed));
    chk({tag, ".status"}, 64'(out_status), 64'(es));
    chk({tag, ".pos"}, 64'(out_err_pos), 64'(ep));
    @(negedge clk);
    if (es == 2'b01 || es == 2'b10) exp_corr = (exp_corr == 3) ? 3 : exp_corr + 1;
    if (es == 2'b11) exp_uncorr = (exp_uncorr == 3) ? 3 : exp_uncorr + 1;
    chk({tag, ".corr"}, 64'(corr_count), 64'(exp_corr));
    chk({tag, ".uncorr"}, 64'(uncorr_count), 64'(exp_uncorr));
  endtask

  logic [31:0] bp_d [0:4];
  logic [7:0]  bp_p [0:4];
  logic [31:0] bp_ed [0:4];
  logic [1:0]  bp_es [0:4];
  logic [31:0] held_data;
  logic [1:0]  held_status;
  logic [5:0]  held_pos;
  logic        was_stall;
  logic        acc;
  int          ii;
  int          oi;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_parity = '0;
    out_ready = 1'b1; cnt_clear = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.out_data", 64'(out_data), 64'd0);
    chk("rst.out_status", 64'(out_status), 64'd0);
    chk("rst.out_err_pos", 64'(out_err_pos), 64'd63);
    chk("rst.corr", 64'(corr_count), 64'd0);
    chk("rst.uncorr", 64'(uncorr_count), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.in_ready", 64'(in_ready), 64'd1);

    run_word("clean1", 32'h00000001, 8'h98, 32'h00000001, 2'b00, 6'd63);
    run_word("cleanff", 32'hFFFFFFFF, 8'h83, 32'hFFFFFFFF, 2'b00, 6'd63);
    run_word("data5", 32'h00000020, 8'h00, 32'h00000000, 2'b01, 6'd5);
    run_word("par2", 32'h00000001, 8'h9C, 32'h00000001, 2'b10, 6'd34);
    run_word("dbl", 32'h00000003, 8'h00, 32'h00000003, 2'b11, 6'd63);
    run_word("data31", 32'h7FFFFFFF, 8'h83, 32'hFFFFFFFF, 2'b01, 6'd31);

    @(negedge clk);
    cnt_clear = 1'b1;
    @(negedge clk);
    cnt_clear = 1'b0;
    exp_corr = 0; exp_uncorr = 0;
    chk("clr.corr", 64'(corr_count), 64'd0);
    chk("clr.uncorr", 64'(uncorr_count), 64'd0);

    // Single-bit sweep over an all-zero codeword; counter saturates at 3.
    for (int i = 0; i < 32; i++)
      run_word($sformatf("sweep_d%0d", i), 32'h1 << i, 8'h00, 32'h0, 2'b01, 6'(i));
    for (int k = 0; k < 8; k++)
      run_word($sformatf("sweep_p%0d", k), 32'h0, 8'h1 << k, 32'h0, 2'b10, 6'(32 + k));
    chk("sat.corr", 64'(corr_count), 64'd3);

    // Clear wins over a same-cycle corrected handshake.
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h00000020; in_parity = 8'h00;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("clrhs.valid", 64'(out_valid), 64'd1);
    cnt_clear = 1'b1;
    @(negedge clk);
    cnt_clear = 1'b0;
    exp_corr = 0;
    chk("clrhs.corr", 64'(corr_count), 64'd0);

    // Backpressure: out_ready low for cycles 2-5 of a 5-word stream.
    bp_d[0] = 32'h00000000; bp_p[0] = 8'h00; bp_ed[0] = 32'h00000000; bp_es[0] = 2'b00;
    bp_d[1] = 32'h00000001; bp_p[1] = 8'h98; bp_ed[1] = 32'h00000001; bp_es[1] = 2'b00;
    bp_d[2] = 32'hFFFFFFFF; bp_p[2] = 8'h83; bp_ed[2] = 32'hFFFFFFFF; bp_es[2] = 2'b00;
    bp_d[3] = 32'h00000020; bp_p[3] = 8'h00; bp_ed[3] = 32'h00000000; bp_es[3] = 2'b01;
    bp_d[4] = 32'h00000003; bp_p[4] = 8'h00; bp_ed[4] = 32'h00000003; bp_es[4] = 2'b11;
    ii = 0; oi = 0; was_stall = 1'b0;
    held_data = '0; held_status = '0; held_pos = '0;
    @(negedge clk);
    in_valid = 1'b1; in_data = bp_d[0]; in_parity = bp_p[0];
    for (int c = 0; c < 30 && oi < 5; c++) begin
      if (c > 0) @(negedge clk);
      out_ready = !(c >= 2 && c <= 5);
      #1;
      if (c == 2) chk("bp.in_ready_low", 64'(in_ready), 64'd0);
      if (was_stall) begin
        chk("bp.hold_data", 64'(out_data), 64'(held_data));
        chk("bp.hold_status", 64'(out_status), 64'(held_status));
        chk("bp.hold_pos", 64'(out_err_pos), 64'(held_pos));
      end
      was_stall = out_valid && !out_ready;
      held_data = out_data; held_status = out_status; held_pos = out_err_pos;
      if (out_valid && out_ready) begin
        chk($sformatf("bp.data%0d", oi), 64'(out_data), 64'(bp_ed[oi]));
        chk($sformatf("bp.status%0d", oi), 64'(out_status), 64'(bp_es[oi]));
        oi++;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        ii++;
        if (ii < 5) begin
          in_data = bp_d[ii]; in_parity = bp_p[ii];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    chk("bp.count", 64'(oi), 64'd5);
    in_valid = 1'b0;
    out_ready = 1'b1;

    // Reset with two words in flight.
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h00000020; in_parity = 8'h00;
    @(negedge clk);
    in_data = 32'h00000003;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid.valid_before", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid.valid_rst", 64'(out_valid), 64'd0);
    chk("mid.pos_rst", 64'(out_err_pos), 64'd63);
    chk("mid.corr_rst", 64'(corr_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("mid.no_out%0d", c), 64'(out_valid), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
